// File: rtl/frame_loader.sv
// frame_loader: assembles one input frame (one dataWidth sample per accepted
// beat) into a flat weightNo*dataWidth bus and emits a high-then-low launch
// strobe (done_out) for the first network layer's input latch.
//
// Optional feature: define FRAME_LOADER_NORM_EN to store in_data[7:0] as an
// unsigned pixel scaled to pixel/256 in Q(dataWidth-fracBits).fracBits.
// Without the macro, in_data is stored verbatim.
module frame_loader #(
    parameter int weightNo     = 784,
    parameter int dataWidth    = 16,
    parameter int fracBits     = 12,
    parameter int launchCycles = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [dataWidth-1:0]          in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    input  logic                          net_busy,
    output logic [weightNo*dataWidth-1:0] out,
    output logic                          done_out,
    output logic                          frame_err,
    output logic                          busy
);

    localparam int IW = (weightNo > 1) ? $clog2(weightNo) : 1;
    localparam int CW = (launchCycles > 1) ? $clog2(launchCycles) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(weightNo - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(launchCycles - 1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        HOLD,
        LAUNCH,
        GAP
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [IW-1:0]        idx;
    logic [CW-1:0]        cnt;
    logic                 accept;
    logic                 at_end;
    logic                 bad_last;
    logic [dataWidth-1:0] sample;

    // Outputs decode the state register only, so nothing from the inputs
    // reaches in_ready, busy or done_out combinationally.
    assign in_ready = (state == FILL);
    assign busy     = (state != FILL);
    assign done_out = (state == LAUNCH);

    assign accept   = in_ready && in_valid;
    assign at_end   = (idx == LAST_IDX);
    assign bad_last = accept && in_last && !at_end;

`ifdef FRAME_LOADER_NORM_EN
    logic [dataWidth-1:0] pixel;
    logic                 unused_upper;

    // Unsigned 8-bit pixel placed so that it reads as pixel/256.
    assign pixel        = {{(dataWidth - 8){1'b0}}, in_data[7:0]};
    assign sample       = pixel << (fracBits - 8);
    assign unused_upper = ^in_data[dataWidth-1:8];
`else
    localparam int unused_frac_bits = fracBits;

    assign sample = in_data;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from
            // pre-edge values, regardless of statement order.
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_nxt
        // unassigned and infers a latch.
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = FILL;
            FILL:    if (accept && at_end) state_nxt = net_busy ? HOLD : LAUNCH;
            HOLD:    if (!net_busy) state_nxt = LAUNCH;
            LAUNCH:  if (cnt == LAST_CNT) state_nxt = GAP;
            GAP:     state_nxt = FILL;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame buffer, slot index, launch counter and framing-error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the frame buffer is a register bank, not a RAM, and its
            // reset value is visible on out, so it is cleared like any flop.
            out       <= '0;
            idx       <= '0;
            cnt       <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= bad_last;
            if (accept) begin
                out[idx*dataWidth +: dataWidth] <= sample;
                // A stray in_last restarts the frame; old slots are simply
                // overwritten by the next attempt.
                idx <= (at_end || in_last) ? '0 : idx + 1'b1;
            end
            cnt <= (state == LAUNCH && cnt != LAST_CNT) ? cnt + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: directed and randomized frames for frame_loader
// (weightNo=4, launchCycles=2), checked against a frame-image model.
module tb_frame_loader;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int FB = 12;
    localparam int LC = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_last;
    logic            in_ready;
    logic            net_busy;
    logic [N*DW-1:0] out;
    logic            done_out;
    logic            frame_err;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the image the latch should see, and samples taken in this frame.
    logic [DW-1:0] img [N];
    int            pos;

    frame_loader #(
        .weightNo    (N),
        .dataWidth   (DW),
        .fracBits    (FB),
        .launchCycles(LC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .net_busy (net_busy),
        .out      (out),
        .done_out (done_out),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] stored(input logic [DW-1:0] d);
`ifdef FRAME_LOADER_NORM_EN
        return DW'(int'(d[7:0]) * (1 << (FB - 8)));
`else
        return d;
`endif
    endfunction

    function automatic logic [N*DW-1:0] img_flat();
        logic [N*DW-1:0] f;
        for (int i = 0; i < N; i++) f[i*DW +: DW] = img[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) img[i] = '0;
        pos = 0;
    endtask

    // Entered at a negedge with the loader in FILL. Waits idle cycles with
    // in_valid low, then offers one beat; returns at the negedge after it.
    task automatic put_beat(input logic [DW-1:0] d, input bit last, input int idle,
                            output bit complete);
        bit err;
        in_valid = 1'b0;
        for (int k = 0; k < idle; k++) begin
            @(negedge clk);
            check("idle_ready", in_ready, 1);
            check("idle_busy", busy, 0);
            check("idle_done", done_out, 0);
            check("idle_err", frame_err, 0);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        err      = last && (pos < N - 1);
        img[pos] = stored(d);
        complete = !err && (pos == N - 1);
        check("beat_out", out, img_flat());
        check("beat_err", frame_err, err);
        if (!complete) begin
            check("beat_ready", in_ready, 1);
            check("beat_done", done_out, 0);
        end
        pos = (err || complete) ? 0 : pos + 1;
    endtask

    // Entered at the negedge right after a frame's final beat.
    task automatic expect_launch(input int hold);
        logic [N*DW-1:0] f;
        f        = img_flat();
        in_valid = 1'b1;              // source keeps pushing; nothing may enter
        in_data  = 16'hDEAD;
        for (int k = 0; k < hold; k++) begin
            if (k > 0) @(negedge clk);
            check("hold_done", done_out, 0);
            check("hold_ready", in_ready, 0);
            check("hold_busy", busy, 1);
            check("hold_out", out, f);
        end
        if (hold > 0) begin
            net_busy = 1'b0;
            @(negedge clk);
        end
        for (int k = 0; k < LC; k++) begin
            if (k > 0) @(negedge clk);
            check("launch_done", done_out, 1);
            check("launch_ready", in_ready, 0);
            check("launch_out", out, f);
            check("launch_err", frame_err, 0);
            if (k == 0) net_busy = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("gap_done", done_out, 0);
        check("gap_ready", in_ready, 0);
        check("gap_out", out, f);
        @(negedge clk);
        check("refill_ready", in_ready, 1);
        check("refill_done", done_out, 0);
        check("refill_out", out, f);
        in_valid = 1'b0;
        net_busy = 1'b0;
    endtask

    logic [DW-1:0] seq [N];
    bit            cmpl;
    bit            lst;
    int            hold;
    int            guard;

    // Directed steps followed by randomized frames.
    initial begin
        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        net_busy = 1'b0;
        model_reset();

        // Reset values.
        #1;
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 1);
        check("rst_done", done_out, 0);
        check("rst_err", frame_err, 0);
        check("rst_out", out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_ready0", in_ready, 0);
        @(negedge clk);
        check("first_ready", in_ready, 1);

        // Basic back-to-back frame 1..4.
        for (int i = 0; i < N; i++) put_beat(DW'(i + 1), i == N - 1, 0, cmpl);
        check("basic_out", out, 64'h0004_0003_0002_0001);
        expect_launch(0);

        // Source backpressure: valid every other cycle, two frames in a row.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < N; i++) put_beat(DW'($urandom), 1'b0, 1, cmpl);
            expect_launch(0);
        end

        // Network busy for 10 cycles after the final beat.
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) net_busy = 1'b1;
            put_beat(DW'($urandom), 1'b0, 0, cmpl);
        end
        expect_launch(10);

        // Framing error on the second beat, then a clean frame A..D.
        put_beat(16'h0011, 1'b0, 0, cmpl);
        put_beat(16'h0022, 1'b1, 0, cmpl);
        seq[0] = 16'h000A; seq[1] = 16'h000B; seq[2] = 16'h000C; seq[3] = 16'h000D;
        for (int i = 0; i < N; i++) put_beat(seq[i], 1'b0, (i == 0) ? 1 : 0, cmpl);
`ifndef FRAME_LOADER_NORM_EN
        check("err_frame_out", out, 64'h000D_000C_000B_000A);
`endif
        expect_launch(0);

`ifdef FRAME_LOADER_NORM_EN
        // Pixel normalisation: 0xFFFF -> 0x0FF0, 0x0080 -> 0x0800.
        put_beat(16'hFFFF, 1'b0, 0, cmpl);
        put_beat(16'h0080, 1'b0, 0, cmpl);
        check("norm_slot0", out[15:0], 16'h0FF0);
        check("norm_slot1", out[31:16], 16'h0800);
        put_beat(16'h1234, 1'b0, 0, cmpl);
        put_beat(16'h00FF, 1'b1, 0, cmpl);
        expect_launch(0);
`endif

        // Asynchronous reset while done_out is high.
        for (int i = 0; i < N; i++) put_beat(DW'($urandom), 1'b0, 0, cmpl);
        check("pre_rst_done", done_out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_done", done_out, 0);
        check("arst_out", out, 0);
        check("arst_ready", in_ready, 0);
        check("arst_busy", busy, 1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_idle_ready", in_ready, 0);
        @(negedge clk);
        check("arst_fill_ready", in_ready, 1);

        // Randomized frames: gaps, stray in_last, random net_busy hold.
        for (int f = 0; f < 10; f++) begin
            hold  = $urandom_range(0, 3);
            cmpl  = 1'b0;
            guard = 0;
            while (!cmpl && guard < 40) begin
                guard++;
                if (pos == N - 1) begin
                    lst      = 1'($urandom_range(0, 1));
                    net_busy = (hold > 0);
                end else begin
                    lst = ($urandom_range(0, 7) == 0);
                end
                put_beat(DW'($urandom), lst, $urandom_range(0, 2), cmpl);
            end
            check("rand_complete", cmpl, 1);
            if (cmpl) expect_launch(hold);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
